// File: rtl/spi_byte_sequencer.sv
// Byte-stream front end for spi_master: TX FIFO feeds one transfer at a time,
// replies are captured into an RX FIFO, and a stalled master raises a sticky error.
module spi_byte_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   spi_start,
  output logic [7:0]             spi_data_in,
  input  logic                   spi_done,
  input  logic [7:0]             spi_data_out,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   clr_err,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [$clog2(DEPTH):0] rx_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, HALT} state_t;
  state_t state, state_next;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic          tx_empty;
  logic [TW-1:0] timer;
  logic          done_d;
  logic [7:0]    cap_byte;

  logic          tx_push, tx_pop, rx_push, rx_pop, done_rise;
  logic          timer_clr, timer_inc, err_set, err_clr, cap_load;
  logic [CW-1:0] tx_count_next, rx_count_next;
  logic [AW-1:0] rx_rd_next;
  logic [7:0]    rx_head_next;

  assign tx_push   = tx_valid && tx_ready;
  assign rx_pop    = rx_valid && rx_ready;
  assign done_rise = spi_done && !done_d;

  // Next occupancy and next RX head, so rx_data can be a plain register
  always_comb begin
    tx_count_next = tx_count;
    if (tx_push && !tx_pop)
      tx_count_next = tx_count + CW'(1);
    else if (!tx_push && tx_pop)
      tx_count_next = tx_count - CW'(1);

    rx_count_next = rx_count;
    if (rx_push && !rx_pop)
      rx_count_next = rx_count + CW'(1);
    else if (!rx_push && rx_pop)
      rx_count_next = rx_count - CW'(1);

    rx_rd_next   = rx_pop ? rx_rd_ptr + AW'(1) : rx_rd_ptr;
    rx_head_next = '0;
    if (rx_count_next != '0) begin
      if (rx_push && (rx_wr_ptr == rx_rd_next))
        rx_head_next = cap_byte;
      else
        rx_head_next = rx_mem[rx_rd_next];
    end
  end

  // Sequencer next-state and control strobes
  always_comb begin
    state_next = state;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    cap_load   = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty && (rx_count < CW'(DEPTH))) begin
          tx_pop     = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_clr  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        // A done edge on the final allowed cycle still counts as success
        if (done_rise) begin
          cap_load   = 1'b1;
          state_next = CAPTURE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          err_set    = 1'b1;
          state_next = HALT;
        end else begin
          timer_inc = 1'b1;
        end
      end
      CAPTURE: begin
        rx_push    = 1'b1;
        state_next = IDLE;
      end
      HALT: begin
        if (clr_err) begin
          err_clr    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wr_ptr] <= tx_data;
    if (rx_push)
      rx_mem[rx_wr_ptr] <= cap_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      tx_count    <= '0;
      rx_count    <= '0;
      tx_ready    <= 1'b1;
      tx_empty    <= 1'b1;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      timer       <= '0;
      done_d      <= 1'b0;
      cap_byte    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      rx_rd_ptr <= rx_rd_next;
      tx_count  <= tx_count_next;
      rx_count  <= rx_count_next;
      tx_ready  <= (tx_count_next != CW'(DEPTH));
      tx_empty  <= (tx_count_next == '0);
      rx_valid  <= (rx_count_next != '0);
      rx_data   <= rx_head_next;
      if (tx_pop)
        spi_data_in <= tx_mem[tx_rd_ptr];
      spi_start <= (state_next == LAUNCH);
      busy      <= (state_next != IDLE);
      if (err_set)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
      if (timer_clr)
        timer <= '0;
      else if (timer_inc)
        timer <= timer + TW'(1);
      done_d <= spi_done;
      if (cap_load)
        cap_byte <= spi_data_out;
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer: queue-based transaction model checked every cycle,
// a reactive master stand-in, and directed scenarios with literal expectations.
module tb_spi_byte_sequencer;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          spi_start;
  logic [7:0]    spi_data_in;
  logic          spi_done = 1'b0;
  logic [7:0]    spi_data_out = '0;
  logic          busy;
  logic          timeout_err;
  logic          clr_err = 1'b0;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;

  spi_byte_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .spi_start(spi_start), .spi_data_in(spi_data_in),
    .spi_done(spi_done), .spi_data_out(spi_data_out),
    .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int e0, p, pe, n0;
  bit ok;
  logic tb_done_q = 1'b0;
  logic [7:0] start_log [$];
  logic [7:0] rx_log [$];
  logic [7:0] exp_burst_rx [4] = '{8'h98, 8'h9B, 8'h9A, 8'h9D};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Edge bookkeeping: cycle number, done rising edges, launches and RX pops
  always @(posedge clk) begin
    cyc++;
    if (spi_done && !tb_done_q) rise_cyc = cyc;
    tb_done_q = spi_done;
    if (spi_start) start_log.push_back(spi_data_in);
    if (rx_valid && rx_ready) rx_log.push_back(rx_data);
  end

  // Master stand-in: answers each start with data_in ^ 0x99 after a programmable delay
  int   master_delay = 1;
  int   master_hold  = 1;
  bit   master_silent = 1'b0;
  logic [7:0] resp_b;
  always begin
    @(negedge clk);
    if (spi_start && !reset && !master_silent) begin
      resp_b = spi_data_in ^ 8'h99;
      repeat (master_delay) @(posedge clk);
      #2;
      spi_data_out = resp_b;
      spi_done     = 1'b1;
      repeat (master_hold) @(posedge clk);
      #2;
      spi_done = 1'b0;
    end
  end

  // Transaction model: byte queues plus the timing rules of the sequencer
  logic [7:0] m_txq [$];
  logic [7:0] m_rxq [$];
  bit   m_inflight = 0, m_halted = 0, m_cap_pend = 0, m_err = 0, m_start = 0, m_done_q = 0;
  bit   m_pop_now, m_push_rx, m_rise;
  logic [7:0] m_din = '0, m_cap = '0;
  int   m_e = 0, m_pop_e = 0, m_ntx, m_nrx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_txq.delete();
      m_rxq.delete();
      m_inflight = 0; m_halted = 0; m_cap_pend = 0; m_err = 0;
      m_start = 0; m_done_q = 0; m_din = '0;
    end else begin
      m_e++;
      m_ntx = m_txq.size();
      m_nrx = m_rxq.size();
      m_rise = spi_done && !m_done_q;
      m_done_q = spi_done;
      m_pop_now = 0;
      m_push_rx = 0;
      if (m_halted) begin
        if (clr_err) begin m_halted = 0; m_err = 0; end
      end else if (m_cap_pend) begin
        m_push_rx = 1; m_cap_pend = 0; m_inflight = 0;
      end else if (m_inflight) begin
        // master window: the TIMEOUT edges following the launch cycle
        if (m_e >= m_pop_e + 2) begin
          if (m_rise) begin
            m_cap = spi_data_out; m_cap_pend = 1;
          end else if (m_e == m_pop_e + 1 + int'(TIMEOUT)) begin
            m_inflight = 0; m_halted = 1; m_err = 1;
          end
        end
      end else if (m_ntx > 0 && m_nrx < int'(DEPTH)) begin
        m_pop_now = 1; m_inflight = 1; m_pop_e = m_e;
      end
      if (rx_ready && m_nrx > 0) void'(m_rxq.pop_front());
      if (m_push_rx) m_rxq.push_back(m_cap);
      if (m_pop_now) m_din = m_txq.pop_front();
      if (tx_valid && m_ntx < int'(DEPTH)) m_txq.push_back(tx_data);
      m_start = m_pop_now;
    end
  end

  always @(negedge clk) begin
    chk("c_tx_ready", 32'(tx_ready), 32'(m_txq.size() < int'(DEPTH)));
    chk("c_tx_count", 32'(tx_count), 32'(m_txq.size()));
    chk("c_rx_valid", 32'(rx_valid), 32'(m_rxq.size() > 0));
    chk("c_rx_count", 32'(rx_count), 32'(m_rxq.size()));
    if (m_rxq.size() > 0) chk("c_rx_data", 32'(rx_data), 32'(m_rxq[0]));
    chk("c_spi_start", 32'(spi_start), 32'(m_start));
    chk("c_spi_data_in", 32'(spi_data_in), 32'(m_din));
    chk("c_busy", 32'(busy), 32'(m_inflight || m_halted));
    chk("c_timeout_err", 32'(timeout_err), 32'(m_err));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    // Reset values
    tick(2);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_counts", 32'({tx_count, rx_count}), 0);
    chk("rst_start", 32'(spi_start), 0);
    reset = 1'b0;
    tick(1);

    // Single byte 0xA5 -> reply 0x3C
    master_delay = 3; master_hold = 3;
    tx_data = 8'hA5; tx_valid = 1'b1; tick(1); e0 = cyc; tx_valid = 1'b0;
    for (int i = 0; i < 10 && !spi_start; i++) tick(1);
    chk("start_lat", 32'(cyc - e0), 1);
    chk("start_din", 32'(spi_data_in), 32'hA5);
    for (int i = 0; i < 30 && !rx_valid; i++) tick(1);
    chk("rx_lat", 32'(cyc - rise_cyc), 1);
    chk("rx_byte", 32'(rx_data), 32'h3C);
    chk("one_start", 32'(start_log.size()), 1);
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;

    // Timeout, pushes while halted, then clear and drain the burst
    master_silent = 1'b1;
    tx_data = 8'hEE; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    for (int i = 0; i < 10 && !spi_start; i++) tick(1);
    p = cyc;
    for (int i = 0; i < 100 && !timeout_err; i++) tick(1);
    chk("to_lat", 32'(cyc - p), 65);
    chk("to_busy", 32'(busy), 1);
    n0 = start_log.size();
    tx_valid = 1'b1;
    for (int b = 1; b <= 4; b++) begin tx_data = 8'(b); tick(1); end
    tx_valid = 1'b0;
    chk("halt_full", 32'(tx_ready), 0);
    chk("halt_cnt", 32'(tx_count), 4);
    tick(3);
    chk("halt_nostart", 32'(start_log.size() - n0), 0);
    master_silent = 1'b0; master_delay = 2; master_hold = 1;
    rx_ready = 1'b1; rx_log.delete();
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    chk("clr_err", 32'(timeout_err), 0);
    for (int i = 0; i < 200 && !(tx_count == '0 && !busy && rx_count == '0); i++) tick(1);
    rx_ready = 1'b0;
    chk("burst_n", 32'(start_log.size() - n0), 4);
    chk("burst_rx_n", 32'(rx_log.size()), 4);
    if (start_log.size() - n0 == 4 && rx_log.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk("burst_tx", 32'(start_log[n0 + k]), 32'(k + 1));
        chk("burst_rx", 32'(rx_log[k]), 32'(exp_burst_rx[k]));
      end

    // Done edge on the last allowed WAIT cycle
    master_delay = 64; master_hold = 1;
    tx_data = 8'h5A; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    for (int i = 0; i < 10 && !spi_start; i++) tick(1);
    p = cyc;
    for (int i = 0; i < 100 && !rx_valid; i++) tick(1);
    chk("lim_edge", 32'(rise_cyc - p), 65);
    chk("lim_err", 32'(timeout_err), 0);
    chk("lim_rx", 32'(rx_data), 32'hC3);
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;

    // Backpressure: RX fills, sequencer stalls idle, one pop releases a launch
    master_delay = 1; master_hold = 1;
    n0 = start_log.size();
    tx_valid = 1'b1;
    for (int b = 0; b < 6; b++) begin
      tx_data = 8'(16 + b);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin ok = tx_ready; tick(1); end
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 300 && !(rx_count == CW'(4) && !busy && tx_count == CW'(2)); i++) tick(1);
    chk("bp_rx_cnt", 32'(rx_count), 4);
    chk("bp_busy", 32'(busy), 0);
    chk("bp_tx_cnt", 32'(tx_count), 2);
    tick(3);
    chk("bp_starts", 32'(start_log.size() - n0), 4);
    rx_ready = 1'b1; tick(1); pe = cyc; rx_ready = 1'b0;
    for (int i = 0; i < 10 && !spi_start; i++) tick(1);
    chk("bp_launch", 32'(cyc - pe), 1);
    chk("bp_din", 32'(spi_data_in), 32'h14);
    rx_ready = 1'b1;
    for (int i = 0; i < 300 && !(tx_count == '0 && !busy && rx_count == '0); i++) tick(1);
    rx_ready = 1'b0;
    chk("bp_drained", 32'(start_log.size() - n0), 6);

    // Reset while waiting on the master with TX=2, RX=1
    tx_data = 8'h20; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    for (int i = 0; i < 50 && !(rx_count == CW'(1) && !busy); i++) tick(1);
    master_silent = 1'b1;
    tx_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin tx_data = 8'(33 + b); tick(1); end
    tx_valid = 1'b0;
    for (int i = 0; i < 10 && !(busy && tx_count == CW'(2)); i++) tick(1);
    chk("pre_rst_occ", 32'({tx_count, rx_count}), 32'({CW'(2), CW'(1)}));
    tick(3);
    reset = 1'b1;
    #1;
    chk("mr_start", 32'(spi_start), 0);
    chk("mr_din", 32'(spi_data_in), 0);
    chk("mr_tx_ready", 32'(tx_ready), 1);
    chk("mr_rx", 32'({rx_valid, rx_data}), 0);
    chk("mr_busy_err", 32'({busy, timeout_err}), 0);
    chk("mr_counts", 32'({tx_count, rx_count}), 0);
    n0 = start_log.size();
    tick(1);
    reset = 1'b0;
    tick(5);
    chk("mr_nostart", 32'(start_log.size() - n0), 0);

    // clr_err while idle is harmless; sequencer still works after reset
    master_silent = 1'b0;
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    chk("idle_clr", 32'({busy, timeout_err}), 0);
    tx_data = 8'h77; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    for (int i = 0; i < 30 && !rx_valid; i++) tick(1);
    chk("post_rst_rx", 32'(rx_data), 32'hEE);
    rx_ready = 1'b1; tick(2); rx_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
